// File: rtl/display_pkg.sv
// Shared types and limits for the prediction display controller.
package display_pkg;

   typedef enum logic [1:0] {RESULT, COUNT, ERRORS} disp_mode_t;
   typedef enum logic [1:0] {IDLE, UPDATE, SHOW} ctrl_state_t;

   localparam int DISP_MAX   = 9999;
   localparam int CONF_MAX   = 99;
   localparam int NUM_DIGITS = 4;
   localparam int CNT_W      = 14;   // smallest width holding DISP_MAX

   // Display mode rotation driven by the mode button.
   function automatic disp_mode_t next_mode(input disp_mode_t m);
      case (m)
         RESULT:  return COUNT;
         COUNT:   return ERRORS;
         default: return RESULT;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Incrementing counter that sticks at DISP_MAX so it never overflows the display.
module sat_counter
   import display_pkg::*;
#(
   parameter int WIDTH = CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Next count: step on enable unless already at the display limit.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q < WIDTH'(DISP_MAX)))
         cnt_d = cnt_q + 1'b1;
   end

   // Count register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign count = cnt_q;

endmodule

// File: rtl/prediction_display_ctrl.sv
// Formats classifier results, counters and busy blink for the 4-digit display.
//
// state  | meaning
// IDLE   | no valid-class result accepted since reset
// UPDATE | one cycle after any accept; not ready
// SHOW   | a valid result is latched and displayed
module prediction_display_ctrl
   import display_pkg::*;
#(
   parameter int INPUT_WIDTH     = 15,
   parameter int BLINK_PRESCALAR = 22
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   res_valid,
   output logic                   res_ready,
   input  logic [3:0]             res_class,
   input  logic [6:0]             res_conf,
   input  logic                   infer_busy,
   input  logic                   mode_btn,
   output logic [INPUT_WIDTH-1:0] number,
   output logic [NUM_DIGITS-1:0]  decimal_points
);

   ctrl_state_t                state_q, state_d;
   disp_mode_t                 mode_q, mode_d;
   logic                       seen_q, seen_d;
   logic [3:0]                 class_q, class_d;
   logic [6:0]                 conf_q, conf_d;
   logic                       ready_q, ready_d;
   logic [BLINK_PRESCALAR:0]   blink_q, blink_d;
   logic [INPUT_WIDTH-1:0]     number_q, number_d;
   logic [NUM_DIGITS-1:0]      dp_q, dp_d;

   logic                       accept;
   logic                       class_ok;
   logic [6:0]                 conf_sat;
   logic [CNT_W-1:0]           res_cnt, err_cnt;
   logic [CNT_W-1:0]           class_ext, class_x1000, result_val;

   assign accept   = res_valid && ready_q;
   assign class_ok = (res_class <= 4'd9);
   assign conf_sat = (res_conf > 7'(CONF_MAX)) ? 7'(CONF_MAX) : res_conf;

   sat_counter #(.WIDTH(CNT_W)) u_res_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .inc     (accept && class_ok),
      .count   (res_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .inc     (accept && !class_ok),
      .count   (err_cnt)
   );

   // class*1000 as x1024 - x16 - x8; max 9216 fits CNT_W without wrap.
   assign class_ext   = CNT_W'(class_q);
   assign class_x1000 = (class_ext << 10) - (class_ext << 4) - (class_ext << 3);
   assign result_val  = class_x1000 + CNT_W'(conf_q);

   // Handshake FSM, result latch and mode rotation.
   always_comb begin
      state_d = state_q;
      seen_d  = seen_q;
      class_d = class_q;
      conf_d  = conf_q;
      mode_d  = mode_q;
      case (state_q)
         UPDATE:  state_d = seen_q ? SHOW : IDLE;
         default: if (accept) state_d = UPDATE;
      endcase
      if (accept && class_ok) begin
         seen_d  = 1'b1;
         class_d = res_class;
         conf_d  = conf_sat;
      end
      if (mode_btn) mode_d = next_mode(mode_q);
      ready_d = (state_d != UPDATE);
   end

   // Output formatting from the registered state; one cycle behind the data.
   always_comb begin
      number_d = '0;
      case (mode_q)
         RESULT:  if (seen_q) number_d = INPUT_WIDTH'(result_val);
         COUNT:   number_d = INPUT_WIDTH'(res_cnt);
         ERRORS:  number_d = INPUT_WIDTH'(err_cnt);
         default: number_d = '0;
      endcase
      dp_d    = {(mode_q == RESULT) && seen_q,
                 mode_q == ERRORS,
                 mode_q == COUNT,
                 infer_busy && blink_q[BLINK_PRESCALAR]};
      blink_d = blink_q + 1'b1;
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         mode_q   <= RESULT;
         seen_q   <= 1'b0;
         class_q  <= '0;
         conf_q   <= '0;
         ready_q  <= 1'b0;
         blink_q  <= '0;
         number_q <= '0;
         dp_q     <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         seen_q   <= seen_d;
         class_q  <= class_d;
         conf_q   <= conf_d;
         ready_q  <= ready_d;
         blink_q  <= blink_d;
         number_q <= number_d;
         dp_q     <= dp_d;
      end
   end

   assign res_ready      = ready_q;
   assign number         = number_q;
   assign decimal_points = dp_q;

endmodule

// File: tb/tb_prediction_display_ctrl.sv
// Directed bench for prediction_display_ctrl with a fast blink prescaler.
module tb_prediction_display_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        res_valid;
   logic        res_ready;
   logic [3:0]  res_class;
   logic [6:0]  res_conf;
   logic        infer_busy;
   logic        mode_btn;
   logic [14:0] number;
   logic [3:0]  decimal_points;

   int n_chk = 0;
   int n_err = 0;

   prediction_display_ctrl #(.INPUT_WIDTH(15), .BLINK_PRESCALAR(3)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_class      (res_class),
      .res_conf       (res_conf),
      .infer_busy     (infer_busy),
      .mode_btn       (mode_btn),
      .number         (number),
      .decimal_points (decimal_points)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic press();
      mode_btn = 1'b1;
      tick();
      mode_btn = 1'b0;
      tick();
   endtask

   task automatic accept_one(input logic [3:0] c, input logic [6:0] f);
      res_valid = 1'b1;
      res_class = c;
      res_conf  = f;
      tick();
      chk("ready_low_in_update", res_ready, 0);
      res_valid = 1'b0;
      tick();
   endtask

   initial begin
      int acc, bad, cyc;
      logic prev, found;

      i_rst_n    = 1'b0;
      res_valid  = 1'b0;
      res_class  = '0;
      res_conf   = '0;
      infer_busy = 1'b0;
      mode_btn   = 1'b0;
      tick();
      tick();
      chk("rst_ready", res_ready, 0);
      chk("rst_number", number, 0);
      chk("rst_dp", decimal_points, 0);

      i_rst_n = 1'b1;
      chk("ready_before_edge", res_ready, 0);
      tick();
      chk("ready_after_release", res_ready, 1);
      chk("idle_number", number, 0);
      chk("idle_dp", decimal_points, 4'b0000);

      // Class 7, conf 42
      accept_one(4'd7, 7'd42);
      chk("r7_number", number, 7042);
      chk("r7_dp", decimal_points, 4'b1000);
      chk("r7_ready", res_ready, 1);

      // Confidence saturation
      accept_one(4'd3, 7'd120);
      chk("r3_number", number, 3099);

      // Invalid class leaves result alone
      accept_one(4'd12, 7'd50);
      chk("inv_number", number, 3099);
      chk("inv_dp", decimal_points, 4'b1000);

      press();
      chk("count_number", number, 2);
      chk("count_dp", decimal_points, 4'b0010);
      press();
      chk("err_number", number, 1);
      chk("err_dp", decimal_points, 4'b0100);
      press();
      chk("wrap_number", number, 3099);
      chk("wrap_dp", decimal_points, 4'b1000);

      // 10001 accepts with valid held high
      acc = 0; bad = 0; cyc = 0;
      prev = res_ready;
      res_valid = 1'b1;
      res_class = 4'd5;
      res_conf  = 7'd5;
      while (acc < 10001 && cyc < 25000) begin
         if (res_ready) acc++;
         tick();
         cyc++;
         if (res_ready == prev) bad++;
         prev = res_ready;
      end
      res_valid = 1'b0;
      chk("held_accepts", acc, 10001);
      chk("held_ready_alternates", bad, 0);
      tick();
      chk("held_result", number, 5005);
      press();
      chk("sat_count", number, 9999);
      chk("sat_dp", decimal_points, 4'b0010);

      // Busy blink: MSB of 4-bit counter, 8 cycles high then 8 low
      infer_busy = 1'b1;
      found = 1'b0;
      prev = decimal_points[0];
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (decimal_points[0] && !prev) found = 1'b1;
         prev = decimal_points[0];
      end
      chk("blink_rise_seen", found, 1);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("blink_high", decimal_points[0], 1);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("blink_low", decimal_points[0], 0);
      end
      tick();
      chk("blink_high_again", decimal_points[0], 1);
      infer_busy = 1'b0;
      tick();
      chk("blink_clear", decimal_points[0], 0);
      chk("blink_clear_dp", decimal_points, 4'b0010);

      // Mode press coincident with an invalid accept (COUNT -> ERRORS)
      mode_btn  = 1'b1;
      res_valid = 1'b1;
      res_class = 4'd14;
      res_conf  = 7'd0;
      tick();
      chk("coinc_ready", res_ready, 0);
      mode_btn  = 1'b0;
      res_valid = 1'b0;
      tick();
      chk("coinc_number", number, 2);
      chk("coinc_dp", decimal_points, 4'b0100);

      // Reset asserted in the middle of UPDATE
      res_valid = 1'b1;
      res_class = 4'd4;
      res_conf  = 7'd10;
      tick();
      res_valid = 1'b0;
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("midrst_number", number, 0);
      chk("midrst_dp", decimal_points, 0);
      chk("midrst_ready", res_ready, 0);
      tick();
      i_rst_n = 1'b1;
      tick();
      chk("post_rst_ready", res_ready, 1);
      chk("post_rst_number", number, 0);
      chk("post_rst_dp", decimal_points, 4'b0000);
      press();
      chk("post_rst_count", number, 0);
      chk("post_rst_count_dp", decimal_points, 4'b0010);
      press();
      chk("post_rst_err", number, 0);
      chk("post_rst_err_dp", decimal_points, 4'b0100);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
